dffsq_pipe_bank: RTL and testbench

//  Parametrised bank of preset-type flops: WIDTH bits x DEPTH stages, sync preset, load enable.

---
 rtl/dffsq_pipe_bank.sv | 71 +++++++
 tb/tb_dffsq_pipe_bank.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dffsq_pipe_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dffsq_pipe_bank
//  Description : WIDTH x DEPTH bank of sync-preset flops with load enable,
//                a per-stage valid tag and a single scan chain.
//  Revision    : 1.0 - initial release
// ============================================================================
module dffsq_pipe_bank #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SETN,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             SO
);

    localparam int c_NBITS = WIDTH * DEPTH;

    // Stage k occupies bits [k*WIDTH +: WIDTH]; this flat order is also the scan order.
    logic [c_NBITS-1:0] r_stg;
    logic [DEPTH-1:0]   r_vld;

    logic [c_NBITS-1:0] w_scan_nxt;
    logic [c_NBITS-1:0] w_adv_nxt;
    logic [DEPTH-1:0]   w_vld_nxt;

    generate
        if (c_NBITS == 1) begin : g_chain_one
            assign w_scan_nxt = SI;
        end else begin : g_chain_many
            assign w_scan_nxt = {r_stg[c_NBITS-2:0], SI};
        end

        if (DEPTH == 1) begin : g_pipe_one
            assign w_adv_nxt = D;
            assign w_vld_nxt = 1'b1;
        end else begin : g_pipe_many
            assign w_adv_nxt = {r_stg[c_NBITS-WIDTH-1:0], D};
            assign w_vld_nxt = {r_vld[DEPTH-2:0], 1'b1};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST || !SETN) begin
            r_stg <= {DEPTH{SET_VAL}};
            r_vld <= '0;
        end else if (SE) begin
            r_stg <= w_scan_nxt;
        end else if (EN) begin
            r_stg <= w_adv_nxt;
            r_vld <= w_vld_nxt;
        end
    end

    // An unknown control would otherwise silently fall through to shift/advance.
    a_ctrl_known: assert property (@(posedge CLK) !RST |-> !$isunknown({SETN, SE}));

    assign Q     = r_stg[c_NBITS-1 -: WIDTH];
    assign VALID = r_vld[DEPTH-1];
    assign SO    = r_stg[c_NBITS-1];

endmodule
`default_nettype wire

// File: tb/tb_dffsq_pipe_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dffsq_pipe_bank
//  Description : Self-checking bench for dffsq_pipe_bank (8 x 2, plus 8 x 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dffsq_pipe_bank;

    localparam int W = 8;
    localparam int N = 2;

    logic         CLK = 1'b0;
    logic         RST, SETN, EN, SE, SI;
    logic [W-1:0] D;
    logic [W-1:0] Q, Q1;
    logic         VALID, SO, VALID1, SO1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: an array of words and their tags.
    logic [W-1:0] m_stg [N];
    bit           m_vld [N];

    always #5 CLK = ~CLK;

    dffsq_pipe_bank #(.WIDTH(W), .DEPTH(N), .SET_VAL(8'hFF)) dut (
        .CLK(CLK), .RST(RST), .SETN(SETN), .EN(EN), .D(D), .SE(SE), .SI(SI),
        .Q(Q), .VALID(VALID), .SO(SO)
    );

    dffsq_pipe_bank #(.WIDTH(W), .DEPTH(1), .SET_VAL(8'hFF)) dut1 (
        .CLK(CLK), .RST(RST), .SETN(SETN), .EN(EN), .D(D), .SE(SE), .SI(SI),
        .Q(Q1), .VALID(VALID1), .SO(SO1)
    );

    task automatic tick(input logic rst, input logic setn, input logic se,
                        input logic en, input logic [W-1:0] d, input logic si);
        bit chain[$];
        @(negedge CLK);
        RST = rst; SETN = setn; SE = se; EN = en; D = d; SI = si;
        @(posedge CLK);
        if (rst || !setn) begin
            for (int k = 0; k < N; k++) begin
                m_stg[k] = 8'hFF;
                m_vld[k] = 1'b0;
            end
        end else if (se) begin
            for (int k = 0; k < N; k++)
                for (int b = 0; b < W; b++)
                    chain.push_back(m_stg[k][b]);
            chain.push_front(si);
            void'(chain.pop_back());
            for (int k = 0; k < N; k++)
                for (int b = 0; b < W; b++)
                    m_stg[k][b] = chain[k*W + b];
        end else if (en) begin
            for (int k = N-1; k > 0; k--) begin
                m_stg[k] = m_stg[k-1];
                m_vld[k] = m_vld[k-1];
            end
            m_stg[0] = d;
            m_vld[0] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset;
        tick(1, 1, 0, 0, 8'h00, 0);
        n_checks++;
        if (Q !== 8'hFF || VALID !== 1'b0 || SO !== 1'b1) begin
            n_fail++;
            $display("FAIL reset: Q=%h VALID=%b SO=%b, required Q=ff VALID=0 SO=1", Q, VALID, SO);
        end
    endtask

    task automatic test_stream;
        tick(0, 1, 0, 1, 8'h3C, 0);
        n_checks++;
        if (Q1 !== 8'h3C || VALID1 !== 1'b1 || SO1 !== 1'b0) begin
            n_fail++;
            $display("FAIL depth1_same_cycle: Q=%h VALID=%b SO=%b, required Q=3c VALID=1 SO=0", Q1, VALID1, SO1);
        end
        n_checks++;
        if (Q !== 8'hFF || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_edge1: Q=%h VALID=%b, required Q=ff VALID=0", Q, VALID);
        end
        tick(0, 1, 0, 1, 8'hA5, 0);
        n_checks++;
        if (Q !== 8'h3C || VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_edge2: Q=%h VALID=%b, required Q=3c VALID=1", Q, VALID);
        end
        tick(0, 1, 0, 1, 8'h00, 0);
        n_checks++;
        if (Q !== 8'hA5 || VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_edge3: Q=%h VALID=%b, required Q=a5 VALID=1", Q, VALID);
        end
    endtask

    task automatic test_stall;
        logic [W-1:0] held;
        tick(0, 1, 0, 1, 8'h11, 0);
        held = Q;
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, 0, 0, 8'hEE, 0);
            n_checks++;
            if (Q !== held || Q !== m_stg[N-1]) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: Q=%h, required %h", i, Q, held);
            end
        end
        tick(0, 1, 0, 1, 8'h22, 0);
        n_checks++;
        if (Q !== 8'h11 || VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resume: Q=%h VALID=%b, required Q=11 VALID=1", Q, VALID);
        end
    endtask

    task automatic test_preset;
        tick(0, 0, 0, 1, 8'h77, 0);
        n_checks++;
        if (Q !== 8'hFF || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL preset: Q=%h VALID=%b, required Q=ff VALID=0", Q, VALID);
        end
        tick(0, 1, 0, 1, 8'h55, 0);
        tick(0, 1, 0, 1, 8'h66, 0);
        n_checks++;
        if (Q !== 8'h55 || VALID !== 1'b1) begin
            n_fail++;
            $display("FAIL preset_drop: Q=%h VALID=%b, required Q=55 VALID=1", Q, VALID);
        end
    endtask

    task automatic test_scan;
        tick(1, 1, 0, 0, 8'h00, 0);
        for (int i = 1; i <= W*N; i++) begin
            tick(0, 1, 1, 1, 8'h99, 0);
            n_checks++;
            if (SO !== ((i < W*N) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL scan_so[%0d]: SO=%b, required %b", i, SO, (i < W*N));
            end
        end
        n_checks++;
        if (Q !== 8'h00 || VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_final: Q=%h VALID=%b, required Q=00 VALID=0", Q, VALID);
        end
        // Scanning over a valid pipeline must leave the tag alone.
        tick(0, 1, 0, 1, 8'h01, 0);
        tick(0, 1, 0, 1, 8'h02, 0);
        tick(0, 1, 1, 0, 8'h00, 1);
        n_checks++;
        if (VALID !== 1'b1 || Q !== 8'h02) begin
            n_fail++;
            $display("FAIL scan_valid_kept: Q=%h VALID=%b, required Q=02 VALID=1", Q, VALID);
        end
    endtask

    task automatic test_priority;
        tick(0, 1, 0, 1, 8'h12, 0);
        tick(0, 1, 0, 1, 8'h34, 0);
        tick(1, 0, 1, 1, 8'h56, 0);
        n_checks++;
        if (Q !== 8'hFF || VALID !== 1'b0 || SO !== 1'b1) begin
            n_fail++;
            $display("FAIL priority: Q=%h VALID=%b SO=%b, required Q=ff VALID=0 SO=1", Q, VALID, SO);
        end
    endtask

    task automatic test_random;
        int r;
        logic rst, setn, se, en, si;
        logic [W-1:0] d;
        for (int i = 0; i < 400; i++) begin
            r    = $urandom_range(0, 99);
            rst  = (r < 3);
            setn = !(r >= 3 && r < 6);
            se   = ($urandom_range(0, 4) == 0);
            en   = $urandom_range(0, 1);
            si   = $urandom_range(0, 1);
            d    = W'($urandom);
            tick(rst, setn, se, en, d, si);
            n_checks++;
            if (Q !== m_stg[N-1] || VALID !== m_vld[N-1] || SO !== m_stg[N-1][W-1]) begin
                n_fail++;
                $display("FAIL random[%0d]: Q=%h VALID=%b SO=%b, required Q=%h VALID=%b SO=%b",
                         i, Q, VALID, SO, m_stg[N-1], m_vld[N-1], m_stg[N-1][W-1]);
            end
        end
    endtask

    initial begin
        RST = 1'b1; SETN = 1'b1; EN = 1'b0; SE = 1'b0; SI = 1'b0; D = '0;
        for (int k = 0; k < N; k++) begin
            m_stg[k] = 8'hFF;
            m_vld[k] = 1'b0;
        end
        test_reset;
        test_stream;
        test_stall;
        test_preset;
        test_scan;
        test_priority;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
